// File: rtl/pwm_stim_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_stim_gen_if : configuration write bus for pwm_stim_gen                  |
// | Optional cfg_phase field exists only when STIM_PHASE_EN is defined.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface pwm_stim_gen_if #(
  parameter int N_CH    = 2,
  parameter int CNT_W   = 16,
  parameter int LVL_W   = 18,
  parameter int BURST_W = 8
);
  localparam int c_ch_w = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic               cfg_valid;
  logic               cfg_ready;
  logic [c_ch_w-1:0]  cfg_ch;
  logic [CNT_W-1:0]   cfg_period;
  logic [CNT_W-1:0]   cfg_high;
  logic [LVL_W-1:0]   cfg_lvl_hi;
  logic [LVL_W-1:0]   cfg_lvl_lo;
  logic [BURST_W-1:0] cfg_burst;
`ifdef STIM_PHASE_EN
  logic [CNT_W-1:0]   cfg_phase;
`endif

  modport master (
`ifdef STIM_PHASE_EN
    output cfg_phase,
`endif
    output cfg_valid, cfg_ch, cfg_period, cfg_high, cfg_lvl_hi, cfg_lvl_lo, cfg_burst,
    input  cfg_ready
  );

  modport slave (
`ifdef STIM_PHASE_EN
    input  cfg_phase,
`endif
    input  cfg_valid, cfg_ch, cfg_period, cfg_high, cfg_lvl_hi, cfg_lvl_lo, cfg_burst,
    output cfg_ready
  );
endinterface
`default_nettype wire

// File: rtl/pwm_stim_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_stim_gen : N-channel programmable PWM / square-wave level source        |
// | Optional macro STIM_PHASE_EN adds a per-channel start phase.                |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module pwm_stim_gen #(
  parameter int N_CH    = 2,
  parameter int CNT_W   = 16,
  parameter int LVL_W   = 18,
  parameter int BURST_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  en,
  pwm_stim_gen_if.slave         cfg_if,
  output logic                  busy,
  output logic                  done,
  output logic [N_CH-1:0]       dig_out,
  output logic [N_CH*LVL_W-1:0] lvl_out,
  output logic [N_CH-1:0]       period_tick
);
  localparam int                 c_ch_w      = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0]   c_cnt_one   = CNT_W'(1);
  localparam logic [BURST_W-1:0] c_burst_one = BURST_W'(1);
  localparam logic [c_ch_w:0]    c_ch_lim    = (c_ch_w+1)'(N_CH);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic [LVL_W-1:0] lvl_hi;
    logic [LVL_W-1:0] lvl_lo;
`ifdef STIM_PHASE_EN
    logic [CNT_W-1:0] phase;
`endif
  } chan_cfg_t;

  state_t                        r_state, w_state_nxt;
  chan_cfg_t [N_CH-1:0]          r_act, r_shd, w_act_nxt, w_shd_nxt;
  logic [N_CH-1:0]               r_pend, w_pend_nxt;
  logic [N_CH-1:0][CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [BURST_W-1:0]            r_burst, w_burst_nxt, r_bcnt, w_bcnt_nxt;
  logic [N_CH-1:0]               r_dig, w_dig_nxt;
  logic [N_CH*LVL_W-1:0]         r_lvl, w_lvl_nxt;
  logic [N_CH-1:0]               w_last, w_load;
  logic [CNT_W-1:0]              w_init;
  chan_cfg_t                     w_wr;
  logic                          w_run, w_step, w_bdone, w_ch_ok, w_accept;

  assign w_ch_ok          = {1'b0, cfg_if.cfg_ch} < c_ch_lim;
  assign cfg_if.cfg_ready = w_ch_ok ? !r_pend[cfg_if.cfg_ch] : 1'b1;
  assign w_accept         = cfg_if.cfg_valid && cfg_if.cfg_ready;
  assign busy             = (r_state == ST_RUN);
  assign dig_out          = r_dig;
  assign lvl_out          = r_lvl;

  always_comb begin
    w_state_nxt = r_state;
    w_act_nxt   = r_act;
    w_shd_nxt   = r_shd;
    w_pend_nxt  = r_pend;
    w_cnt_nxt   = r_cnt;
    w_burst_nxt = r_burst;
    w_bcnt_nxt  = r_bcnt;
    w_dig_nxt   = '0;
    w_lvl_nxt   = '0;
    w_last      = '0;
    w_load      = '0;
    w_init      = '0;
    period_tick = '0;
    done        = 1'b0;
    w_run       = (r_state == ST_RUN);
    w_step      = w_run && en;

    w_wr.period = cfg_if.cfg_period;
    w_wr.high   = cfg_if.cfg_high;
    w_wr.lvl_hi = cfg_if.cfg_lvl_hi;
    w_wr.lvl_lo = cfg_if.cfg_lvl_lo;
`ifdef STIM_PHASE_EN
    w_wr.phase  = cfg_if.cfg_phase;
`endif

    for (int k = 0; k < N_CH; k++) begin
      w_last[k]      = (r_act[k].period != '0) && (r_cnt[k] == r_act[k].period - c_cnt_one);
      period_tick[k] = w_step && w_last[k];
    end

    // Burst progress is measured on channel 0 only; stop pre-empts completion.
    w_bdone = period_tick[0] && (r_burst != '0) && (r_bcnt == r_burst - c_burst_one);
    case (r_state)
      ST_IDLE: if (start && !stop) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_bdone) begin
          w_state_nxt = ST_IDLE;
          done        = 1'b1;
        end else if (period_tick[0] && (r_burst != '0)) begin
          w_bcnt_nxt = r_bcnt + c_burst_one;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_state_nxt == ST_IDLE) w_bcnt_nxt = '0;

    // A zero-period channel never wraps, so it takes new shadow data on any running cycle.
    for (int k = 0; k < N_CH; k++) begin
      w_load[k] = r_pend[k] && (!w_run || (w_step && ((r_act[k].period == '0) || w_last[k])));
      if (w_load[k]) begin
        w_act_nxt[k]  = r_shd[k];
        w_pend_nxt[k] = 1'b0;
      end
    end

    if (w_accept) begin
      w_burst_nxt = cfg_if.cfg_burst;
      if (w_ch_ok) begin
        w_shd_nxt[cfg_if.cfg_ch]  = w_wr;
        w_pend_nxt[cfg_if.cfg_ch] = 1'b1;
      end
    end

    for (int k = 0; k < N_CH; k++) begin
`ifdef STIM_PHASE_EN
      w_init = (w_act_nxt[k].phase < w_act_nxt[k].period) ? w_act_nxt[k].phase : '0;
`else
      w_init = '0;
`endif
      if (w_state_nxt != ST_RUN)                             w_cnt_nxt[k] = '0;
      else if (!w_run)                                       w_cnt_nxt[k] = w_init;
      else if (w_step && w_load[k])                          w_cnt_nxt[k] = w_init;
      else if (w_step && (w_last[k] || r_act[k].period == '0)) w_cnt_nxt[k] = '0;
      else if (w_step)                                       w_cnt_nxt[k] = r_cnt[k] + c_cnt_one;

      w_dig_nxt[k] = (w_state_nxt == ST_RUN) && (w_act_nxt[k].period != '0) &&
                     (w_cnt_nxt[k] < w_act_nxt[k].high);
      w_lvl_nxt[k*LVL_W +: LVL_W] = w_dig_nxt[k] ? w_act_nxt[k].lvl_hi : w_act_nxt[k].lvl_lo;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_act   <= '0;
      r_shd   <= '0;
      r_pend  <= '0;
      r_cnt   <= '0;
      r_burst <= '0;
      r_bcnt  <= '0;
      r_dig   <= '0;
      r_lvl   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_act   <= w_act_nxt;
      r_shd   <= w_shd_nxt;
      r_pend  <= w_pend_nxt;
      r_cnt   <= w_cnt_nxt;
      r_burst <= w_burst_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_dig   <= w_dig_nxt;
      r_lvl   <= w_lvl_nxt;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pwm_stim_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pwm_stim_gen : scoreboard bench for pwm_stim_gen                         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_pwm_stim_gen;
  localparam int N_CH    = 2;
  localparam int CNT_W   = 16;
  localparam int LVL_W   = 18;
  localparam int BURST_W = 8;
  localparam int CH_W    = 1;
  localparam logic [LVL_W-1:0] LV_P = LVL_W'(65536);   // +1.0 in Q2.16
  localparam logic [LVL_W-1:0] LV_N = LVL_W'(-65536);  // -1.0 in Q2.16

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, stop = 1'b0, en = 1'b1;
  logic busy, done;
  logic [N_CH-1:0] dig_out, period_tick;
  logic [N_CH*LVL_W-1:0] lvl_out;

  pwm_stim_gen_if #(.N_CH(N_CH), .CNT_W(CNT_W), .LVL_W(LVL_W), .BURST_W(BURST_W)) cfg_if ();

  pwm_stim_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .LVL_W(LVL_W), .BURST_W(BURST_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .cfg_if(cfg_if),
    .busy(busy), .done(done), .dig_out(dig_out), .lvl_out(lvl_out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic [N_CH-1:0]       dig;
    logic [N_CH-1:0]       tick;
    logic                  ready;
    logic [N_CH*LVL_W-1:0] lvl;
  } exp_t;

  typedef struct {
    int               period;
    int               high;
    logic [LVL_W-1:0] hi;
    logic [LVL_W-1:0] lo;
    int               phase;
  } mcfg_t;

  mcfg_t act [N_CH];
  mcfg_t shd [N_CH];
  bit    pend [N_CH];
  int    pos [N_CH];
  bit    m_run;
  int    m_burst, m_bcnt;
  int    wr_phase = 0;
  exp_t  sb[$];
  int    total = 0, bad = 0;

  function automatic void model_reset();
    for (int k = 0; k < N_CH; k++) begin
      act[k] = '{0, 0, '0, '0, 0};
      shd[k] = '{0, 0, '0, '0, 0};
      pend[k] = 1'b0;
      pos[k]  = 0;
    end
    m_run = 1'b0; m_burst = 0; m_bcnt = 0;
  endfunction

  function automatic int start_pos(input mcfg_t c);
`ifdef STIM_PHASE_EN
    return (c.phase < c.period) ? c.phase : 0;
`else
    return (c.period >= 0) ? 0 : 0;
`endif
  endfunction

  // Expected outputs for the current cycle, from the model state and present inputs.
  function automatic exp_t model_expect();
    exp_t e;
    e = '0;
    e.busy = m_run;
    for (int k = 0; k < N_CH; k++) begin
      e.dig[k] = m_run && (act[k].period > 0) && (pos[k] < act[k].high);
      e.lvl[k*LVL_W +: LVL_W] = e.dig[k] ? act[k].hi : act[k].lo;
      e.tick[k] = m_run && en && (act[k].period > 0) && (pos[k] == act[k].period - 1);
    end
    e.done  = m_run && !stop && e.tick[0] && (m_burst != 0) && (m_bcnt == m_burst - 1);
    e.ready = !pend[int'(cfg_if.cfg_ch)];
    return e;
  endfunction

  function automatic void model_advance(input exp_t e);
    bit nxt_run;
    bit loaded [N_CH];
    int ch;
    ch = int'(cfg_if.cfg_ch);
    nxt_run = m_run ? (!stop && !e.done) : (start && !stop);
    if (!nxt_run) m_bcnt = 0;
    else if (e.tick[0] && m_burst != 0) m_bcnt++;
    for (int k = 0; k < N_CH; k++) begin
      loaded[k] = pend[k] && (!m_run || (en && (act[k].period == 0 || pos[k] == act[k].period - 1)));
      if (loaded[k]) begin
        act[k]  = shd[k];
        pend[k] = 1'b0;
      end
    end
    if (cfg_if.cfg_valid && e.ready) begin
      m_burst       = int'(cfg_if.cfg_burst);
      shd[ch].period = int'(cfg_if.cfg_period);
      shd[ch].high   = int'(cfg_if.cfg_high);
      shd[ch].hi     = cfg_if.cfg_lvl_hi;
      shd[ch].lo     = cfg_if.cfg_lvl_lo;
`ifdef STIM_PHASE_EN
      shd[ch].phase  = int'(cfg_if.cfg_phase);
`else
      shd[ch].phase  = 0;
`endif
      pend[ch] = 1'b1;
    end
    for (int k = 0; k < N_CH; k++) begin
      if (!nxt_run) pos[k] = 0;
      else if (!m_run || (en && loaded[k])) pos[k] = start_pos(act[k]);
      else if (en && act[k].period > 0) pos[k] = (pos[k] + 1) % act[k].period;
    end
    m_run = nxt_run;
  endfunction

  task automatic cycle_step();
    exp_t e;
    if (!rst) model_reset();
    e = model_expect();
    sb.push_back(e);
    if (rst) model_advance(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic write_cfg(input int ch, input int per, input int hi_t,
                           input logic [LVL_W-1:0] vh, input logic [LVL_W-1:0] vl, input int b);
    int guard;
    guard = 0;
    cfg_if.cfg_ch = CH_W'(ch);
    while (pend[ch] && guard < 100) begin
      cycle_step();
      guard++;
    end
    cfg_if.cfg_period = CNT_W'(per);
    cfg_if.cfg_high   = CNT_W'(hi_t);
    cfg_if.cfg_lvl_hi = vh;
    cfg_if.cfg_lvl_lo = vl;
    cfg_if.cfg_burst  = BURST_W'(b);
`ifdef STIM_PHASE_EN
    cfg_if.cfg_phase  = CNT_W'(wr_phase);
`endif
    cfg_if.cfg_valid  = 1'b1;
    cycle_step();
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare against the oldest expectation.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        a = {busy, done, dig_out, period_tick, cfg_if.cfg_ready, lvl_out};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL cycle t=%0t: got busy=%b done=%b dig=%b tick=%b ready=%b lvl=%h expected busy=%b done=%b dig=%b tick=%b ready=%b lvl=%h",
                   $time, a.busy, a.done, a.dig, a.tick, a.ready, a.lvl,
                   e.busy, e.done, e.dig, e.tick, e.ready, e.lvl);
        end
      end
    end
  end

  initial begin
    int highs, done_at, ticks;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_period = '0; cfg_if.cfg_high = '0;
    cfg_if.cfg_lvl_hi = '0; cfg_if.cfg_lvl_lo = '0; cfg_if.cfg_burst = '0;
`ifdef STIM_PHASE_EN
    cfg_if.cfg_phase = '0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", {busy, done, dig_out, period_tick, cfg_if.cfg_ready}, 64'b0000001);
    check("reset_lvl", 64'(lvl_out), 64'd0);
    rst = 1'b1;
    cycle_step();

    // Basic 10-cycle square wave, 50% duty
    write_cfg(0, 10, 5, LV_P, LV_N, 0);
`ifdef STIM_PHASE_EN
    wr_phase = 5;
`endif
    write_cfg(1, 10, 5, LV_P, LV_N, 0);
    wr_phase = 0;
    repeat (2) cycle_step();
    start = 1'b1;
    cycle_step();
    for (int i = 1; i <= 22; i++) begin
      if (i == 1) check("t1_lvl_hi", 64'(lvl_out[LVL_W-1:0]), 64'(LV_P));
      if (i == 6) check("t1_lvl_lo", 64'(lvl_out[LVL_W-1:0]), 64'(LV_N));
`ifdef STIM_PHASE_EN
      if (i == 1) check("phase_c1", 64'(dig_out), 64'b01);
      if (i == 6) check("phase_c6", 64'(dig_out), 64'b10);
`else
      if (i == 1) check("inphase_c1", 64'(dig_out), 64'b11);
`endif
      cycle_step();
    end

    // Asynchronous reset during a high phase
    rst = 1'b0;
    #1;
    check("rst_async", {busy, dig_out, lvl_out}, 64'd0);
    cycle_step();
    rst = 1'b1;
    cycle_step();
    start = 1'b1;
    cycle_step();
    repeat (2) cycle_step();
    check("rst_cfg_cleared", {busy, dig_out}, 64'b100);
    stop = 1'b1;
    cycle_step();

    // Burst of three periods
    write_cfg(0, 4, 1, LV_P, LV_N, 3);
    write_cfg(1, 0, 0, '0, '0, 3);
    repeat (2) cycle_step();
    start = 1'b1;
    cycle_step();
    highs = 0; done_at = 0;
    for (int i = 1; i <= 16; i++) begin
      if (dig_out[0]) highs++;
      if (done && done_at == 0) done_at = i;
      cycle_step();
    end
    check("burst_highs", 64'(highs), 64'd3);
    check("burst_done_cycle", 64'(done_at), 64'd12);
    check("burst_idle", {busy, 46'(lvl_out[LVL_W-1:0])}, {1'b0, 46'(LV_N)});

    // Reshape mid-period: takes effect only at the next wrap
    write_cfg(0, 8, 2, LV_P, LV_N, 0);
    write_cfg(1, 0, 0, '0, '0, 0);
    start = 1'b1;
    cycle_step();
    repeat (3) cycle_step();
    write_cfg(0, 4, 3, LV_N, LV_P, 0);
    cycle_step();
    check("reshape_ready_low", 64'(cfg_if.cfg_ready), 64'd0);
    repeat (12) cycle_step();
    stop = 1'b1;
    cycle_step();

    // Boundary shapes: high=0, high=period, period=0
    write_cfg(0, 6, 0, LV_P, LV_N, 0);
    start = 1'b1;
    cycle_step();
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      if (dig_out[0]) highs++;
      cycle_step();
    end
    check("high0_never_high", 64'(highs), 64'd0);
    stop = 1'b1;
    cycle_step();
    write_cfg(0, 6, 6, LV_P, LV_N, 0);
    start = 1'b1;
    cycle_step();
    highs = 0; ticks = 0;
    for (int i = 1; i <= 13; i++) begin
      if (dig_out[0]) highs++;
      if (period_tick[0]) ticks++;
      cycle_step();
    end
    check("fullhigh_highs", 64'(highs), 64'd13);
    check("fullhigh_ticks", 64'(ticks), 64'd2);
    stop = 1'b1;
    cycle_step();
    write_cfg(0, 0, 3, LV_P, LV_N, 0);
    start = 1'b1;
    cycle_step();
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      if (period_tick[0] || dig_out[0]) ticks++;
      cycle_step();
    end
    check("period0_quiet", 64'(ticks), 64'd0);
    stop = 1'b1;
    cycle_step();

    // start&stop together, then a 3-cycle enable stall
    start = 1'b1; stop = 1'b1;
    cycle_step();
    check("start_stop_idle", 64'(busy), 64'd0);
    write_cfg(0, 10, 5, LV_P, LV_N, 0);
    start = 1'b1;
    cycle_step();
    repeat (7) cycle_step();
    en = 1'b0;
    repeat (3) cycle_step();
    en = 1'b1;
    repeat (15) cycle_step();
    stop = 1'b1;
    cycle_step();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      en    = ($urandom_range(0, 9) != 0);
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      cfg_if.cfg_ch     = CH_W'($urandom_range(0, N_CH - 1));
      cfg_if.cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_if.cfg_period = CNT_W'($urandom_range(0, 12));
      cfg_if.cfg_high   = CNT_W'($urandom_range(0, 14));
      cfg_if.cfg_lvl_hi = LVL_W'($urandom);
      cfg_if.cfg_lvl_lo = LVL_W'($urandom);
      cfg_if.cfg_burst  = ($urandom_range(0, 2) == 0) ? BURST_W'($urandom_range(1, 5)) : '0;
`ifdef STIM_PHASE_EN
      cfg_if.cfg_phase  = CNT_W'($urandom_range(0, 12));
`endif
      cycle_step();
    end

    repeat (2) cycle_step();
    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
